// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame controller.
//   - frame_state_e : FSM state codes (IDLE, LEN, DATA, CHK, HOLD)
//   - DEFAULT_SYNC_BYTE : default frame start marker
//   - CRC8_POLY : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   - next_check() : folds one byte into the running check value
// Build option: define UART_FRAME_CRC8_EN to make the check byte a CRC-8
// (poly 0x07, init 0x00, no reflection, no final XOR) over LEN and payload;
// otherwise the check byte is the XOR of LEN and all payload bytes.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_HOLD = 3'd4
    } frame_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CRC8_POLY         = 8'h07;

    // Starting from acc = 8'h00 and folding LEN first gives the init value
    // for both builds (XOR: acc = LEN; CRC: acc = crc(LEN)).
    function automatic logic [7:0] next_check(input logic [7:0] acc,
                                              input logic [7:0] data);
`ifdef UART_FRAME_CRC8_EN
        logic [7:0] crc;
        crc = acc ^ data;
        for (int i = 0; i < 8; i++) begin
            crc = crc[7] ? ({crc[6:0], 1'b0} ^ CRC8_POLY) : {crc[6:0], 1'b0};
        end
        return crc;
`else
        return acc ^ data;
`endif
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_buf.sv
// Payload buffer for the UART frame controller.
// MAX_LEN x 8 register array, one write port, one registered read port.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (read register only)
//   wr_en/addr/data   : payload write port
//   rd_addr           : read index
//   rd_len            : length of the held frame; indices >= rd_len read 0
//   rd_en             : a frame is held; otherwise reads return 0
//   rd_data           : registered read data, one-cycle latency
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [LW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [LW-1:0] rd_addr,
    input  logic [LW-1:0] rd_len,
    input  logic          rd_en,
    output logic [7:0]    rd_data
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0] mem [MAX_LEN];

    // Contents are not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < LW'(MAX_LEN))) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // rd_len never exceeds MAX_LEN, so the range check also bounds the index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (rd_en && (rd_addr < rd_len)) begin
            rd_data <= mem[rd_addr[AW-1:0]];
        end else begin
            rd_data <= 8'h00;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller. Groups bytes from the UART byte receiver into
// frames SYNC, LEN, LEN payload bytes, CHK; buffers and validates them, and
// holds one good frame for a local consumer.
// Build option: UART_FRAME_CRC8_EN selects a CRC-8 check byte instead of XOR.
// Ports:
//   ip_Clock, ip_Rst_n        : clock, synchronous active-low reset
//   ip_Rx_DV, ip_Rx_Byte      : one-cycle byte strobe and byte from the UART
//   ip_Rd_Addr, op_Rd_Data    : random-access payload read, one-cycle latency
//   ip_Frame_Ack              : consumer releases the held frame
//   op_Frame_Valid, op_Frame_Len : held frame present and its payload length
//   op_Busy                   : frame reception in progress (LEN, DATA, CHK)
//   op_Err_Len/Chk/Timeout/Drop : one-cycle error pulses
//
// Consumer handshake: op_Frame_Valid rises the cycle after a good check byte
// and stays high, with buffer and op_Frame_Len frozen, until the consumer
// asserts ip_Frame_Ack for one cycle; op_Frame_Valid then falls on the next
// cycle. A byte arriving in the ack cycle is treated as if the FSM were idle.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 2080,
    localparam int        LW           = $clog2(MAX_LEN + 1)
) (
    input  logic          ip_Clock,
    input  logic          ip_Rst_n,
    input  logic          ip_Rx_DV,
    input  logic [7:0]    ip_Rx_Byte,
    input  logic [LW-1:0] ip_Rd_Addr,
    input  logic          ip_Frame_Ack,
    output logic          op_Frame_Valid,
    output logic [LW-1:0] op_Frame_Len,
    output logic [7:0]    op_Rd_Data,
    output logic          op_Busy,
    output logic          op_Err_Len,
    output logic          op_Err_Chk,
    output logic          op_Err_Timeout,
    output logic          op_Err_Drop
);
    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    localparam logic [2:0] S_IDLE = 3'(ST_IDLE);
    localparam logic [2:0] S_LEN  = 3'(ST_LEN);
    localparam logic [2:0] S_DATA = 3'(ST_DATA);
    localparam logic [2:0] S_CHK  = 3'(ST_CHK);
    localparam logic [2:0] S_HOLD = 3'(ST_HOLD);

    logic [2:0]    state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] count;
    logic [7:0]    acc;
    logic [TW-1:0] tmo;

    logic len_ok;
    logic tmo_hit;
    logic is_sync;
    logic buf_wr;

    assign op_Busy = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    assign len_ok  = (ip_Rx_Byte != 8'h00) && (ip_Rx_Byte <= 8'(MAX_LEN));
    assign tmo_hit = (tmo == TMO_LAST);
    assign is_sync = ip_Rx_DV && (ip_Rx_Byte == SYNC_BYTE);
    assign buf_wr  = (state == S_DATA) && ip_Rx_DV;

    uart_frame_buf #(.MAX_LEN(MAX_LEN), .LW(LW)) u_buf (
        .clk     (ip_Clock),
        .rst_n   (ip_Rst_n),
        .wr_en   (buf_wr),
        .wr_addr (count),
        .wr_data (ip_Rx_Byte),
        .rd_addr (ip_Rd_Addr),
        .rd_len  (op_Frame_Len),
        .rd_en   (state == S_HOLD),
        .rd_data (op_Rd_Data)
    );

    always_ff @(posedge ip_Clock) begin
        if (!ip_Rst_n) begin
            state          <= S_IDLE;
            len_q          <= '0;
            count          <= '0;
            acc            <= 8'h00;
            tmo            <= '0;
            op_Frame_Valid <= 1'b0;
            op_Frame_Len   <= '0;
            op_Err_Len     <= 1'b0;
            op_Err_Chk     <= 1'b0;
            op_Err_Timeout <= 1'b0;
            op_Err_Drop    <= 1'b0;
        end else begin
            op_Err_Len     <= 1'b0;
            op_Err_Chk     <= 1'b0;
            op_Err_Timeout <= 1'b0;
            op_Err_Drop    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (is_sync) state <= S_LEN;
                end
                S_LEN: begin
                    if (ip_Rx_DV) begin
                        if (len_ok) begin
                            len_q <= ip_Rx_Byte[LW-1:0];
                            acc   <= next_check(8'h00, ip_Rx_Byte);
                            count <= '0;
                            state <= S_DATA;
                        end else begin
                            op_Err_Len <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        op_Err_Timeout <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (ip_Rx_DV) begin
                        acc   <= next_check(acc, ip_Rx_Byte);
                        count <= count + 1'b1;
                        if (count == len_q - 1'b1) state <= S_CHK;
                    end else if (tmo_hit) begin
                        op_Err_Timeout <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_CHK: begin
                    if (ip_Rx_DV) begin
                        if (ip_Rx_Byte == acc) begin
                            op_Frame_Valid <= 1'b1;
                            op_Frame_Len   <= len_q;
                            state          <= S_HOLD;
                        end else begin
                            op_Err_Chk <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        op_Err_Timeout <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (ip_Frame_Ack) begin
                        // Release and apply IDLE rules to a same-cycle byte.
                        op_Frame_Valid <= 1'b0;
                        state          <= is_sync ? S_LEN : S_IDLE;
                    end else if (ip_Rx_DV) begin
                        op_Err_Drop <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Inter-byte timer: runs only while receiving; any byte restarts it
            // and a byte in the expiry cycle takes priority over the timeout.
            if (op_Busy && !ip_Rx_DV && !tmo_hit) begin
                tmo <= tmo + 1'b1;
            end else begin
                tmo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl (default parameters).
module tb_uart_rx_frame_ctrl;
    localparam int MAX_LEN = 16;
    localparam int LW      = 5;
    localparam int TMO     = 2080;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic [LW-1:0] rd_addr = '0;
    logic          frame_ack = 1'b0;

    logic          frame_valid;
    logic [LW-1:0] frame_len;
    logic [7:0]    rd_data;
    logic          busy;
    logic          err_len, err_chk, err_tmo, err_drop;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_len  = 0;
    int cnt_chk  = 0;
    int cnt_tmo  = 0;
    int cnt_drop = 0;

    logic [7:0] pl [MAX_LEN];
    logic [7:0] exp_q [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    uart_rx_frame_ctrl dut (
        .ip_Clock       (clk),
        .ip_Rst_n       (rst_n),
        .ip_Rx_DV       (rx_dv),
        .ip_Rx_Byte     (rx_byte),
        .ip_Rd_Addr     (rd_addr),
        .ip_Frame_Ack   (frame_ack),
        .op_Frame_Valid (frame_valid),
        .op_Frame_Len   (frame_len),
        .op_Rd_Data     (rd_data),
        .op_Busy        (busy),
        .op_Err_Len     (err_len),
        .op_Err_Chk     (err_chk),
        .op_Err_Timeout (err_tmo),
        .op_Err_Drop    (err_drop)
    );

    // Error pulse monitor, sampled mid-cycle: counts pulses, checks exclusivity.
    always @(negedge clk) begin
        int hi;
        hi = int'(err_len === 1'b1) + int'(err_chk === 1'b1)
           + int'(err_tmo === 1'b1) + int'(err_drop === 1'b1);
        cnt_len  += int'(err_len === 1'b1);
        cnt_chk  += int'(err_chk === 1'b1);
        cnt_tmo  += int'(err_tmo === 1'b1);
        cnt_drop += int'(err_drop === 1'b1);
        if (hi > 0) begin
            n_checks++;
            if (hi > 1) $display("FAIL err_exclusive: %0d pulses high, want 1", hi);
            else n_pass++;
        end
    end

    // ---------------- driver tasks (all return at posedge + 1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom_range(0, 255));
    endtask

    task automatic read_at(input int a, output logic [7:0] d);
        rd_addr = LW'(a);
        @(posedge clk);
        #1;
        d = rd_data;
    endtask

    task automatic fill_payload(input int n);
        for (int i = 0; i < n; i++) begin
            pl[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(pl[i]);
        end
    endtask

    // Reference check byte from the frame definition: LEN then payload.
    function automatic logic [7:0] ref_check(input int n);
        logic [7:0] msg [$];
        logic [7:0] r;
        logic       fb;
        msg.push_back(8'(n));
        for (int i = 0; i < n; i++) msg.push_back(pl[i]);
        r = 8'h00;
`ifdef UART_FRAME_CRC8_EN
        // Polynomial division of the MSB-first bit stream by x^8+x^2+x+1.
        foreach (msg[j]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[j][b];
                r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
`else
        fb = 1'b0;
        foreach (msg[j]) r = r ^ msg[j];
`endif
        return r;
    endfunction

    // SYNC, LEN, n payload bytes from pl[], CHK, with random short gaps.
    task automatic send_frame(input logic [7:0] len_byte, input int n,
                              input logic [7:0] chk, input int gap_max);
        send_byte(8'hA5);
        tick($urandom_range(0, gap_max));
        send_byte(len_byte);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, gap_max));
            send_byte(pl[i]);
        end
        tick($urandom_range(0, gap_max));
        send_byte(chk);
    endtask

    // Held-frame check: valid, length, every payload byte, one out-of-range read.
    task automatic check_held(input int n, input string tag);
        logic [7:0] d;
        logic [7:0] e;
        int         oor;
        n_checks++;
        if (frame_valid !== 1'b1) $display("FAIL %s_valid: got %b want 1", tag, frame_valid);
        else n_pass++;
        n_checks++;
        if (frame_len !== LW'(n)) $display("FAIL %s_len: got %0d want %0d", tag, frame_len, n);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            read_at(i, d);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) $display("FAIL %s_rd[%0d]: got %h want %h", tag, i, d, e);
            else n_pass++;
        end
        oor = (n == MAX_LEN) ? n : $urandom_range(n, n + 2);
        read_at(oor, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL %s_rd_oor[%0d]: got %h want 00", tag, oor, d);
        else n_pass++;
    endtask

    task automatic ack_frame(input string tag);
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
        n_checks++;
        if (frame_valid !== 1'b0) $display("FAIL %s_ack_valid: got %b want 0", tag, frame_valid);
        else n_pass++;
    endtask

    task automatic check_all_zero(input string tag);
        logic [7+LW+6:0] got;
        got = {frame_valid, frame_len, rd_data, busy, err_len, err_chk, err_tmo, err_drop};
        n_checks++;
        if (got !== '0) $display("FAIL %s_outputs: got %h want 0", tag, got);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        logic [7:0] d;
        int e0;
        e0 = cnt_len + cnt_chk + cnt_tmo + cnt_drop;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        for (int i = 0; i < 3; i++) exp_q.push_back(pl[i]);
        send_frame(8'h03, 3, 8'h03, 0);
        check_held(3, "basic");
        n_checks++;
        if (cnt_len + cnt_chk + cnt_tmo + cnt_drop !== e0)
            $display("FAIL basic_no_err: got %0d pulses want 0", cnt_len + cnt_chk + cnt_tmo + cnt_drop - e0);
        else n_pass++;
        ack_frame("basic");
        read_at(0, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL basic_rd_after_ack: got %h want 00", d);
        else n_pass++;
    endtask

    task automatic test_bad_chk();
        int c0;
        c0 = cnt_chk;
        pl[0] = 8'hAA; pl[1] = 8'h55;
        send_frame(8'h02, 2, 8'h00, 1);
        tick(2);
        n_checks++;
        if (cnt_chk - c0 !== 1) $display("FAIL chk_pulse: got %0d want 1", cnt_chk - c0);
        else n_pass++;
        n_checks++;
        if ({frame_valid, busy} !== 2'b00) $display("FAIL chk_state: valid/busy got %b want 00", {frame_valid, busy});
        else n_pass++;
    endtask

    task automatic test_bad_len();
        int c0;
        c0 = cnt_len;
        send_byte(8'hA5); send_byte(8'h00);
        tick(1);
        send_byte(8'hA5); send_byte(8'h11);
        tick(2);
        n_checks++;
        if (cnt_len - c0 !== 2) $display("FAIL len_pulse: got %0d want 2", cnt_len - c0);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL len_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int at;
        int c0;
        int n;
        c0 = cnt_tmo;
        at = -1;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        for (int k = 1; k <= TMO + 200; k++) begin
            tick(1);
            if (err_tmo === 1'b1) begin
                at = k;
                break;
            end
        end
        n_checks++;
        if (at !== TMO) $display("FAIL tmo_delay: got %0d clocks want %0d", at, TMO);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL tmo_busy: got %b want 0", busy);
        else n_pass++;
        tick(1);
        n_checks++;
        if (cnt_tmo - c0 !== 1) $display("FAIL tmo_pulse: got %0d want 1", cnt_tmo - c0);
        else n_pass++;
        n = $urandom_range(1, MAX_LEN);
        fill_payload(n);
        send_frame(8'(n), n, ref_check(n), 3);
        check_held(n, "tmo_next");
        ack_frame("tmo_next");
    endtask

    task automatic test_drop_and_ack();
        logic [7:0] d;
        int c0;
        int n;
        n = $urandom_range(2, MAX_LEN);
        fill_payload(n);
        send_frame(8'(n), n, ref_check(n), 2);
        check_held(n, "drop_pre");
        c0 = cnt_drop;
        send_byte(8'hA5);
        tick(1);
        n_checks++;
        if (cnt_drop - c0 !== 1) $display("FAIL drop_pulse: got %0d want 1", cnt_drop - c0);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            read_at(i, d);
            n_checks++;
            if (d !== pl[i]) $display("FAIL drop_rd[%0d]: got %h want %h", i, d, pl[i]);
            else n_pass++;
        end
        frame_ack = 1'b1;
        send_byte(8'hA5);
        frame_ack = 1'b0;
        n_checks++;
        if ({busy, frame_valid} !== 2'b10) $display("FAIL ack_sync: busy/valid got %b want 10", {busy, frame_valid});
        else n_pass++;
        pl[0] = 8'h7E;
        exp_q.push_back(8'h7E);
        send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        check_held(1, "ack_sync_frame");
        n_checks++;
        if (cnt_drop - c0 !== 1) $display("FAIL ack_no_drop: got %0d want 1", cnt_drop - c0);
        else n_pass++;
        ack_frame("ack_sync_frame");
    endtask

    task automatic test_reset_mid_data();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        rst_n = 1'b0;
        tick(1);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        pl[0] = 8'h01;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1, 8'h00, 0);
        check_held(1, "post_reset");
        ack_frame("post_reset");
    endtask

    task automatic test_back_to_back();
        int kind, n, e0, c0;
        logic [7:0] chk;
        logic [7:0] lb;
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 9);
            n    = $urandom_range(1, MAX_LEN);
            if ($urandom_range(0, 3) == 0) begin
                lb = 8'($urandom_range(0, 255));
                send_byte((lb == 8'hA5) ? 8'h5A : lb);
            end
            if (kind == 0) begin
                c0 = cnt_len;
                lb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
                send_byte(8'hA5); send_byte(lb);
                tick(1);
                n_checks++;
                if (cnt_len - c0 !== 1) $display("FAIL b2b_len[%0d]: got %0d want 1 (len %h)", it, cnt_len - c0, lb);
                else n_pass++;
            end else if (kind == 1) begin
                c0 = cnt_chk;
                for (int i = 0; i < n; i++) pl[i] = 8'($urandom_range(0, 255));
                chk = ref_check(n) ^ (8'h01 << $urandom_range(0, 7));
                send_frame(8'(n), n, chk, 1);
                tick(1);
                n_checks++;
                if ({cnt_chk - c0, frame_valid} !== {32'd1, 1'b0})
                    $display("FAIL b2b_chk[%0d]: got pulses %0d valid %b want 1/0", it, cnt_chk - c0, frame_valid);
                else n_pass++;
            end else begin
                e0 = cnt_len + cnt_chk + cnt_tmo + cnt_drop;
                fill_payload(n);
                send_frame(8'(n), n, ref_check(n), 1);
                check_held(n, "b2b_good");
                n_checks++;
                if (cnt_len + cnt_chk + cnt_tmo + cnt_drop !== e0)
                    $display("FAIL b2b_no_err[%0d]: got %0d pulses want 0", it, cnt_len + cnt_chk + cnt_tmo + cnt_drop - e0);
                else n_pass++;
                ack_frame("b2b_good");
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_drop_and_ack();
        test_reset_mid_data();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
